fifo_param_ctrl: RTL and testbench

//   Synchronous FIFO controller, the access side of the mem_param storage block.

---
 rtl/fifo_param_ctrl_pkg.sv | 16 +
 rtl/fifo_param_ctrl_mem.sv | 28 ++
 rtl/fifo_param_ctrl.sv | 76 +++++++
 tb/tb_fifo_param_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_ctrl_pkg.sv
// Shared defaults and width helpers for the fifo_param_ctrl / mem_param pair.
package fifo_param_ctrl_pkg;

    localparam int WIDTH_DEF = 1024;
    localparam int DEPTH_DEF = 8;

    // Pointers carry one extra wrap bit; count also covers the output register.
    function automatic int ptr_w(input int depth);
        return depth + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return depth + 2;
    endfunction

endpackage

// File: rtl/fifo_param_ctrl_mem.sv
// mem_param: 2**DEPTH x WIDTH storage, synchronous write, asynchronous read.
module mem_param
    import fifo_param_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             write,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    // NOTE: storage arrays are deliberately not reset; the pointers alone decide
    // which entries are valid, and a reset port would stop RAM inference.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_ctrl.sv
// Synchronous FIFO controller: valid/ready write port into mem_param, and a
// registered first-word-fall-through output stage on the read port.
module fifo_param_ctrl
    import fifo_param_ctrl_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [WIDTH-1:0] rdata;
    logic             mem_empty;
    logic             mem_full;
    logic             wr_fire;
    logic             load;
    logic             pop;

    assign mem_empty = (wptr == rptr);
    assign mem_full  = (wptr[DEPTH-1:0] == rptr[DEPTH-1:0]) && (wptr[DEPTH] != rptr[DEPTH]);

    // wr_ready looks only at registered state (and rst), never at rd_ready.
    assign wr_ready = !rst && !mem_full;
    assign wr_fire  = wr_valid && wr_ready;
    assign load     = !mem_empty && (!rd_valid || rd_ready);
    assign pop      = rd_valid && rd_ready;

    mem_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .write (wr_fire),
        .waddr (wptr[DEPTH-1:0]),
        .wdata (wr_data),
        .raddr (rptr[DEPTH-1:0]),
        .rdata (rdata)
    );

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            count    <= '0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (load) begin
                rd_data  <= rdata;
                rd_valid <= 1'b1;
                rptr     <= rptr + PTR_W'(1);
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            count <= count + CNT_W'(wr_fire) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Directed bench for fifo_param_ctrl at WIDTH=8, DEPTH=2 (4-word memory, capacity 5).
module tb_fifo_param_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [DEPTH+1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    fifo_param_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        step(); step();
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_single();
        wr_valid = 1'b1; wr_data = 8'hA1;
        step();
        wr_valid = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b want 0", rd_valid); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count_early: got %0d want 1", count); end
        step();
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL single_rd_valid: got %b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 8'hA1) begin n_err++; $display("FAIL single_rd_data: got %h want a1", rd_data); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0) begin
            n_err++; $display("FAIL single_drain: got valid=%b count=%0d want valid=0 count=0", rd_valid, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b want 1", i, wr_ready); end
            step();
        end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", wr_ready); end
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL fill_count: got %0d want 5", count); end
        wr_data = 8'h06;
        step();
        wr_valid = 1'b0;
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL fill_sixth_count: got %0d want 5", count); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_sixth_ready: got %b want 0", wr_ready); end
        n_cmp++; if (rd_data !== 8'h01) begin n_err++; $display("FAIL fill_head: got %h want 01", rd_data); end
    endtask

    task automatic test_drain();
        rd_ready = 1'b1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready_same_cycle: got %b want 0", wr_ready); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'(i + 1)) begin
                n_err++; $display("FAIL drain_word_%0d: got valid=%b data=%h want valid=1 data=%h", i, rd_valid, rd_data, 8'(i + 1));
            end
            step();
            if (i == 0) begin
                n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready_next_cycle: got %b want 1", wr_ready); end
            end
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_end_valid: got %b want 0", rd_valid); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_end_count: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        int widx = 0;
        int ridx = 0;
        int max_cnt = 0;
        int bad = 0;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && ridx < 20; cyc++) begin
            wr_valid = (widx < 20);
            wr_data  = 8'(widx);
            if (rd_valid) begin
                if (rd_data !== 8'(ridx)) begin
                    bad++;
                    $display("FAIL stream_word_%0d: got %h want %h", ridx, rd_data, 8'(ridx));
                end
                ridx++;
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (wr_valid && wr_ready) widx++;
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (bad != 0) n_err++;
        n_cmp++; if (ridx != 20) begin n_err++; $display("FAIL stream_received: got %0d want 20", ridx); end
        n_cmp++; if (max_cnt > 2) begin n_err++; $display("FAIL stream_max_count: got %0d want <=2", max_cnt); end
        n_cmp++; if (count !== 4'd0 || rd_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_end: got count=%0d valid=%b want 0/0", count, rd_valid);
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 8'h55; vals[1] = 8'h66; vals[2] = 8'h77; vals[3] = 8'h88;
        rd_ready = 1'b0;
        wr_valid = 1'b1; wr_data = vals[0];
        step();
        for (int i = 1; i < 4; i++) begin
            wr_data = vals[i];
            step();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin
                n_err++; $display("FAIL hold_cycle_%0d: got valid=%b data=%h want valid=1 data=55", i, rd_valid, rd_data);
            end
        end
        wr_valid = 1'b0;
        n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL hold_count: got %0d want 4", count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_data !== vals[i]) begin n_err++; $display("FAIL hold_order_%0d: got %h want %h", i, rd_data, vals[i]); end
            step();
        end
        rd_ready = 1'b0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL hold_end_count: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'hC0 + 8'(i);
            step();
        end
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL rstmid_pre_count: got %0d want 3", count); end
        wr_data = 8'hDD; rd_ready = 1'b1; rst = 1'b1;
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready_during: got %b want 0", wr_ready); end
        step();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", rd_data); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready_held: got %b want 0", wr_ready); end
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_after: got %b want 1", wr_ready); end
        step(); step();
        n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0) begin
            n_err++; $display("FAIL rstmid_discard: got valid=%b count=%0d want 0/0", rd_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
